apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_pkg.sv | 22 ++
 rtl/apb_master_bridge.sv | 139 +++++++++++++
 2 files changed

// File: rtl/apb_master_pkg.sv
// ============================================================================
//  Module      : apb_master_pkg
//  Description : Shared types and constants for the APB master bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] c_align_mask = 2'b11;

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
//  Module      : apb_master_bridge
//  Description : Single-outstanding request/response to APB master bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // Counter keeps at least one bit so TIMEOUT_CYCLES=0 still elaborates.
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e                r_state;
  apb_state_e                w_next_state;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_pwrite;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;

  logic w_handshake;
  logic w_misaligned;
  logic w_timeout;

  assign w_handshake  = req_valid && (r_state == ST_IDLE);
  assign w_misaligned = |(req_addr[1:0] & c_align_mask);
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && !PREADY && (r_cnt == c_cnt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_next_state = w_misaligned ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY || w_timeout) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    PSEL      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    PENABLE   = (r_state == ST_ACCESS);
    rsp_valid = (r_state == ST_RESP);
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            if (w_misaligned) begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_paddr  <= req_addr;
              r_pwdata <= req_wdata;
              r_pwrite <= req_write;
            end
          end
        end
        ST_SETUP: r_cnt <= '0;
        ST_ACCESS: begin
          if (PREADY) begin
            r_rsp_err   <= PSLVERR;
            r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
